// File: rtl/imem_boot_ctrl.sv
// Instruction-memory boot/fetch controller: streams a loader image into IMEM from word 0, then gates fetch.
// Optional IMEM_FETCH_BOUNDS_EN halts the pipeline on a fetch past the loaded image.
module imem_boot_ctrl #(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned AW    = 7,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_start,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  input  logic          fetch_req,
  input  logic [31:0]   fetch_pc,
  output logic [AW-1:0] mem_raddr,
  output logic          fetch_stall,
  output logic          fetch_inst_valid,
  output logic [AW:0]   load_count,
  output logic          halt,
  output logic          err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HALT} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [AW:0]   count_q, count_d;
  logic          err_q, err_d;
  logic          halt_q, halt_d;

`ifdef IMEM_FETCH_BOUNDS_EN
  logic in_range;
  assign in_range = fetch_pc < 32'(count_q);
`else
  logic unused_pc_hi;
  assign unused_pc_hi = ^fetch_pc[31:AW];
`endif

  always_comb begin
    state_d          = state_q;
    waddr_d          = waddr_q;
    count_d          = count_q;
    err_d            = err_q;
    ld_ready         = 1'b0;
    mem_we           = 1'b0;
    mem_waddr        = '0;
    mem_wdata        = '0;
    fetch_stall      = 1'b1;
    fetch_inst_valid = 1'b0;
    mem_raddr        = '0;

    case (state_q)
      S_LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          mem_we    = 1'b1;
          mem_waddr = waddr_q;
          mem_wdata = ld_data;
          count_d   = count_q + 1'b1;
          // The top word is never followed by an increment, so waddr cannot wrap.
          if (ld_last) begin
            state_d = S_RUN;
          end else if (waddr_q == AW'(DEPTH - 1)) begin
            state_d = S_HALT;
            err_d   = 1'b1;
          end else begin
            waddr_d = waddr_q + 1'b1;
          end
        end
      end
      S_RUN: begin
        fetch_stall = 1'b0;
        mem_raddr   = fetch_pc[AW-1:0];
`ifdef IMEM_FETCH_BOUNDS_EN
        fetch_inst_valid = fetch_req && in_range;
        if (!ld_start && fetch_req && !in_range) state_d = S_HALT;
`else
        fetch_inst_valid = fetch_req;
`endif
      end
      default: ;
    endcase

    // Reload wins over any RUN/HALT transition decided above; LOAD ignores it.
    if (ld_start && state_q != S_LOAD) begin
      state_d = S_LOAD;
      waddr_d = '0;
      count_d = '0;
      err_d   = 1'b0;
    end

    halt_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      waddr_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      count_q <= count_d;
      err_q   <= err_d;
      halt_q  <= halt_d;
    end
  end

  assign load_count = count_q;
  assign halt       = halt_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl: load, gaps, fetch range, overflow, reload priority, reset mid-load.
`define CHK(tag, obs, exp) chk(tag, 64'(obs), 64'(exp))

module tb_imem_boot_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_start, ld_valid, ld_last;
  logic [31:0] ld_data;
  logic        ld_ready, mem_we;
  logic [6:0]  mem_waddr, mem_raddr;
  logic [31:0] mem_wdata;
  logic        fetch_req;
  logic [31:0] fetch_pc;
  logic        fetch_stall, fetch_inst_valid;
  logic [7:0]  load_count;
  logic        halt, err;

  int checks   = 0;
  int failures = 0;

  imem_boot_ctrl #(.DEPTH(128), .AW(7), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .fetch_req(fetch_req), .fetch_pc(fetch_pc), .mem_raddr(mem_raddr),
    .fetch_stall(fetch_stall), .fetch_inst_valid(fetch_inst_valid),
    .load_count(load_count), .halt(halt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past exactly one rising edge; inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    `CHK({tag, "_cnt"},   load_count, 0);
    `CHK({tag, "_err"},   err, 0);
    `CHK({tag, "_halt"},  halt, 0);
    `CHK({tag, "_rdy"},   ld_ready, 0);
    `CHK({tag, "_we"},    mem_we, 0);
    `CHK({tag, "_waddr"}, mem_waddr, 0);
    `CHK({tag, "_wdata"}, mem_wdata, 0);
    `CHK({tag, "_stall"}, fetch_stall, 1);
    `CHK({tag, "_fiv"},   fetch_inst_valid, 0);
    `CHK({tag, "_raddr"}, mem_raddr, 0);
  endtask

  logic [31:0] prog [3];
  logic        gap_v [5];
  int          gap_a [5];
  int          bad;
  int          nwr;

  initial begin
    prog[0] = 32'h8C0100FB; prog[1] = 32'h8C0200FC; prog[2] = 32'h00221820;
    gap_v[0] = 1'b1; gap_v[1] = 1'b0; gap_v[2] = 1'b0; gap_v[3] = 1'b1; gap_v[4] = 1'b1;
    gap_a[0] = 0; gap_a[1] = 0; gap_a[2] = 0; gap_a[3] = 1; gap_a[4] = 2;

    rst = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
    fetch_req = 1'b0; fetch_pc = '0;
    tick(); tick();
    #1 chk_reset("reset");
    rst = 1'b0;

    // Three back-to-back words, last on the third.
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    #1 `CHK("load_rdy", ld_ready, 1);
    `CHK("load_cnt0", load_count, 0);
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_data = prog[i]; ld_last = (i == 2);
      #1 `CHK("w_we", mem_we, 1);
      `CHK("w_addr", mem_waddr, i);
      `CHK("w_data", mem_wdata, prog[i]);
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    #1 `CHK("rel_stall", fetch_stall, 0);
    `CHK("rel_cnt", load_count, 3);
    `CHK("rel_we", mem_we, 0);

    // Fetch at the last loaded word, then one past it.
    fetch_req = 1'b1; fetch_pc = 32'd2;
    #1 `CHK("f2_fiv", fetch_inst_valid, 1);
    `CHK("f2_raddr", mem_raddr, 2);
    tick();
    fetch_pc = 32'd3;
`ifdef IMEM_FETCH_BOUNDS_EN
    #1 `CHK("f3_fiv", fetch_inst_valid, 0);
    tick();
    #1 `CHK("f3_halt", halt, 1);
    `CHK("f3_stall", fetch_stall, 1);
`else
    #1 `CHK("f3_fiv", fetch_inst_valid, 1);
    `CHK("f3_raddr", mem_raddr, 3);
    tick();
    #1 `CHK("f3_halt", halt, 0);
    `CHK("f3_stall", fetch_stall, 0);
`endif
    fetch_req = 1'b0; fetch_pc = '0;

    // Reload with loader gaps 1,0,0,1,1(last).
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    nwr = 0;
    for (int i = 0; i < 5; i++) begin
      ld_valid = gap_v[i]; ld_data = 32'hA0 + 32'(i); ld_last = (i == 4);
      #1 `CHK("gap_rdy", ld_ready, 1);
      `CHK("gap_we", mem_we, gap_v[i]);
      if (gap_v[i]) begin
        `CHK("gap_addr", mem_waddr, gap_a[i]);
        nwr++;
      end
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    #1 `CHK("gap_cnt", load_count, nwr);
    `CHK("gap_stall", fetch_stall, 0);

    // ld_start together with an out-of-range fetch: reload wins.
    ld_start = 1'b1; fetch_req = 1'b1; fetch_pc = 32'd3;
    tick();
    ld_start = 1'b0; fetch_req = 1'b0; fetch_pc = '0;
    #1 `CHK("sim_halt", halt, 0);
    `CHK("sim_stall", fetch_stall, 1);
    `CHK("sim_cnt", load_count, 0);
    `CHK("sim_rdy", ld_ready, 1);

    // 128 words with no ld_last overflow the image.
    bad = 0;
    for (int i = 0; i < 128; i++) begin
      ld_valid = 1'b1; ld_last = 1'b0; ld_data = 32'hDEAD0000 ^ 32'(i);
      #1;
      if (!(mem_we === 1'b1 && mem_waddr === 7'(i) && mem_wdata === (32'hDEAD0000 ^ 32'(i)))) bad++;
      if (i == 127) begin
        `CHK("ovf_cnt127", load_count, 127);
        `CHK("ovf_err_pre", err, 0);
      end
      tick();
    end
    ld_valid = 1'b0;
    `CHK("ovf_writes", bad, 0);
    #1 `CHK("ovf_err", err, 1);
    `CHK("ovf_halt", halt, 1);
    `CHK("ovf_cnt", load_count, 128);
    `CHK("ovf_stall", fetch_stall, 1);
    `CHK("ovf_rdy", ld_ready, 0);

    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    #1 `CHK("clr_err", err, 0);
    `CHK("clr_cnt", load_count, 0);
    `CHK("clr_halt", halt, 0);

    // Reset after five accepted words.
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1'b1; ld_data = 32'h5000 + 32'(i);
      tick();
    end
    #1 `CHK("mid_cnt5", load_count, 5);
    rst = 1'b1; ld_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1 chk_reset("mid_rst");
    ld_valid = 1'b1; ld_data = 32'h1234;
    #1 `CHK("idle_we", mem_we, 0);
    ld_start = 1'b1; ld_valid = 1'b0;
    tick();
    ld_start = 1'b0; ld_valid = 1'b1; ld_data = 32'h0BADF00D;
    #1 `CHK("re_we", mem_we, 1);
    `CHK("re_addr", mem_waddr, 0);
    `CHK("re_data", mem_wdata, 32'h0BADF00D);
    tick();
    ld_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
